t_counter: RTL and testbench

- Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit bank of toggle stages with two modes.
- Counter mode: up/down counting with wrap or saturate, parallel load and a terminal pulse.
- Toggle mode: each bit is a T flip-flop driven by its own toggle_mask bit.
- Used in the RLE path as the run-length counter and as a general toggle register; keeps the complementary q/not_q outputs.

---
 rtl/t_counter.sv | 120 ++++++++++++
 tb/tb_t_counter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/t_counter.sv
// WIDTH-bit toggle-stage bank: up/down counter (wrap or saturate) or per-bit T flip-flops.
// Optional input capture register enabled by defining T_COUNTER_CAPTURE_EN.
module t_counter #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SATURATE    = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             up,
  input  logic [WIDTH-1:0] toggle_mask,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`ifdef T_COUNTER_CAPTURE_EN
  input  logic             capture,
  output logic [WIDTH-1:0] capture_q,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] not_q,
  output logic             terminal,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] AllOnes = '1;
  localparam logic [WIDTH-1:0] OneVal  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] not_q_q;
  logic             terminal_q, terminal_d;
  // Set while q sits on a saturation bound that has already produced its pulse.
  logic             hit_q, hit_d;

  always_comb begin
    q_d        = q_q;
    terminal_d = 1'b0;
    hit_d      = hit_q;
    if (load) begin
      q_d   = load_value;
      hit_d = 1'b0;
    end else if (enable) begin
      if (mode) begin
        q_d   = q_q ^ toggle_mask;
        hit_d = 1'b0;
      end else if (up) begin
        if (q_q == AllOnes) begin
          if (SATURATE) begin
            terminal_d = ~hit_q;
            hit_d      = 1'b1;
          end else begin
            q_d        = '0;
            terminal_d = 1'b1;
            hit_d      = 1'b0;
          end
        end else begin
          q_d   = q_q + OneVal;
          hit_d = 1'b0;
        end
      end else begin
        if (q_q == '0) begin
          if (SATURATE) begin
            terminal_d = ~hit_q;
            hit_d      = 1'b1;
          end else begin
            q_d        = AllOnes;
            terminal_d = 1'b1;
            hit_d      = 1'b0;
          end
        end else begin
          q_d   = q_q - OneVal;
          hit_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      q_q        <= RESET_VALUE;
      not_q_q    <= ~RESET_VALUE;
      terminal_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      q_q        <= q_d;
      not_q_q    <= ~q_d;
      terminal_q <= terminal_d;
      hit_q      <= hit_d;
    end
  end

`ifdef T_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] capture_q_q, capture_q_d;

  always_comb begin
    capture_q_d = capture_q_q;
    if (capture) begin
      capture_q_d = q_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      capture_q_q <= '0;
    end else begin
      capture_q_q <= capture_q_d;
    end
  end

  assign capture_q = capture_q_q;
`endif

  assign q        = q_q;
  assign not_q    = not_q_q;
  assign terminal = terminal_q;
  assign at_max   = (q_q == AllOnes);
  assign at_min   = (q_q == '0);

endmodule

// File: tb/tb_t_counter.sv
// Bench for t_counter: a wrapping and a saturating 4-bit instance driven in parallel,
// checked every edge against an arithmetic reference model.
module tb_t_counter;
  localparam int W = 4;
  localparam int MaxV = 15;

  logic         clock = 1'b0;
  logic         reset, enable, mode, up, load, capture;
  logic [W-1:0] toggle_mask, load_value;
  logic [W-1:0] q0, nq0, q1, nq1, cq0, cq1;
  logic         t0, t1, mx0, mx1, mn0, mn1;

  int n_tests = 0;
  int n_fail  = 0;

  int rv[2]  = '{0, 10};
  int sat[2] = '{0, 1};
  int m_q[2];
  int m_term[2];
  int m_parked[2];
  int m_cap[2];

  always #5 clock = ~clock;

  t_counter #(.WIDTH(W), .RESET_VALUE(4'd0), .SATURATE(1'b0)) u_wrap (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .up(up),
    .toggle_mask(toggle_mask), .load(load), .load_value(load_value),
`ifdef T_COUNTER_CAPTURE_EN
    .capture(capture), .capture_q(cq0),
`endif
    .q(q0), .not_q(nq0), .terminal(t0), .at_max(mx0), .at_min(mn0)
  );

  t_counter #(.WIDTH(W), .RESET_VALUE(4'd10), .SATURATE(1'b1)) u_sat (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .up(up),
    .toggle_mask(toggle_mask), .load(load), .load_value(load_value),
`ifdef T_COUNTER_CAPTURE_EN
    .capture(capture), .capture_q(cq1),
`endif
    .q(q1), .not_q(nq1), .terminal(t1), .at_max(mx1), .at_min(mn1)
  );

`ifndef T_COUNTER_CAPTURE_EN
  assign cq0 = '0;
  assign cq1 = '0;
`endif

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Next state from the behavioural rules using plain integer arithmetic.
  task automatic model_edge();
    for (int s = 0; s < 2; s++) begin
      int nxt;
      if (!reset) begin
        m_q[s] = rv[s]; m_term[s] = 0; m_parked[s] = 0; m_cap[s] = 0;
      end else begin
        if (capture) m_cap[s] = m_q[s];
        m_term[s] = 0;
        if (load) begin
          m_q[s] = int'(load_value); m_parked[s] = 0;
        end else if (enable && mode) begin
          m_q[s] = m_q[s] ^ int'(toggle_mask); m_parked[s] = 0;
        end else if (enable) begin
          nxt = up ? m_q[s] + 1 : m_q[s] - 1;
          if (nxt < 0 || nxt > MaxV) begin
            if (sat[s] != 0) begin
              m_term[s] = (m_parked[s] == 0) ? 1 : 0;
              m_parked[s] = 1;
            end else begin
              m_q[s] = (nxt + MaxV + 1) % (MaxV + 1);
              m_term[s] = 1;
            end
          end else begin
            m_q[s] = nxt; m_parked[s] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare();
    check("wrap.q", int'(q0), m_q[0]);
    check("wrap.not_q", int'(nq0), (~m_q[0]) & MaxV);
    check("wrap.terminal", int'(t0), m_term[0]);
    check("wrap.at_max", int'(mx0), int'(m_q[0] == MaxV));
    check("wrap.at_min", int'(mn0), int'(m_q[0] == 0));
    check("sat.q", int'(q1), m_q[1]);
    check("sat.not_q", int'(nq1), (~m_q[1]) & MaxV);
    check("sat.terminal", int'(t1), m_term[1]);
    check("sat.at_max", int'(mx1), int'(m_q[1] == MaxV));
    check("sat.at_min", int'(mn1), int'(m_q[1] == 0));
`ifdef T_COUNTER_CAPTURE_EN
    check("wrap.capture_q", int'(cq0), m_cap[0]);
    check("sat.capture_q", int'(cq1), m_cap[1]);
`endif
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    compare();
  endtask

  task automatic drive(input logic r, input logic ld, input int lv, input logic en,
                       input logic md, input logic u, input int mask, input logic cap);
    reset = r; load = ld; load_value = W'(lv); enable = en; mode = md; up = u;
    toggle_mask = W'(mask); capture = cap;
    cycle();
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; load_value = '0; enable = 1'b0; mode = 1'b0; up = 1'b1;
    toggle_mask = '0; capture = 1'b0;
    for (int i = 0; i < 4; i++) m_q[i % 2] = 0;

    drive(0, 0, 0, 0, 0, 1, 0, 0);
    check("reset.q", int'(q0), 0);

    // Count up through the wrap point.
    for (int i = 0; i < 16; i++) drive(1, 0, 0, 1, 0, 1, 0, 0);
    check("wrap.to_zero", int'(q0), 0);
    check("wrap.pulse", int'(t0), 1);

    // Saturation: load 14, four up edges, one down, two up.
    drive(1, 1, 14, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 0, 1, 0, 0);
    check("sat.hold", int'(q1), 15);
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    check("sat.leave", int'(q1), 14);
    for (int i = 0; i < 2; i++) drive(1, 0, 0, 1, 0, 1, 0, 0);

    // Down from zero.
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 0, 0, 0, 0);

    // Toggle mode.
    drive(1, 1, 10, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 1, 0, 6, 0);
    check("toggle.once", int'(q0), 12);
    drive(1, 0, 0, 1, 1, 1, 6, 0);
    check("toggle.twice", int'(q0), 10);

    // Priority cases.
    drive(1, 1, 9, 1, 0, 1, 0, 0);
    check("load_over_enable", int'(q0), 9);
    drive(0, 1, 3, 1, 0, 1, 0, 0);
    check("reset_over_load", int'(q1), 10);
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 1, 0, 1, 0, 0);
    check("mid_count", int'(q0), 7);
    drive(0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 0, 1, 0, 0);
    check("resume", int'(q0), 3);

    // Capture of the pre-update value.
    drive(1, 1, 5, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 0, 1, 0, 1);
    drive(1, 0, 0, 1, 0, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 32) != 0, ($urandom % 8) == 0, int'($urandom % 16),
            ($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 3) != 0,
            int'($urandom % 16), ($urandom % 6) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
